// File: rtl/sym_dn_lut_pkg.sv
// rtl/sym_dn_lut_pkg.sv - shared types, defaults and geometry helpers for the decision-node LUT loader
// The VERIFY state only exists when SYM_DN_LUT_VERIFY_EN is defined.
package sym_dn_lut_pkg;

  localparam int DEF_LUT_DEPTH = 128;
  localparam int DEF_ADDR_W    = 7;
  localparam int DEF_WORD_W    = 16;
  localparam int WORDS_PER_LUT = DEF_LUT_DEPTH / DEF_WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DONE   = 2'd2
`ifdef SYM_DN_LUT_VERIFY_EN
    , ST_VERIFY = 2'd3
`endif
  } state_e;

  // Depth must be a power of two addressed exactly by ADDR_W, and whole words must fill it.
  function automatic bit lut_geom_ok(input int depth, input int addr_w, input int word_w);
    return (depth == 2 ** addr_w) && (word_w > 0) && ((depth % word_w) == 0);
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sym_dn_lut_ser.sv
// rtl/sym_dn_lut_ser.sv - word buffer and LSB-first bit serialiser feeding the LUT write port
// s_ready is raised while the last buffered bit is on the output so words stream without gaps.
module sym_dn_lut_ser
  import sym_dn_lut_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int N_WORDS = WORDS_PER_LUT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              bit_data,
  output logic              bit_valid
);

  localparam int CNT_W = cnt_width(WORD_W);
  localparam int WC_W  = $clog2(N_WORDS + 1);

  logic [WORD_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [WC_W-1:0]   words_q, words_d;
  logic              active_q, active_d;
  logic              s_ready_q, s_ready_d;
  logic              bit_q, bit_d;
  logic              vld_q, vld_d;
  logic              accept;

  always_comb begin
    accept   = s_valid && s_ready_q;
    sh_d     = sh_q;
    rem_d    = rem_q;
    words_d  = words_q;
    bit_d    = bit_q;
    vld_d    = 1'b0;
    if (start) begin
      sh_d    = '0;
      rem_d   = '0;
      words_d = '0;
    end else if (accept) begin
      bit_d   = s_data[0];
      vld_d   = 1'b1;
      sh_d    = s_data >> 1;
      rem_d   = CNT_W'(WORD_W - 1);
      words_d = words_q + WC_W'(1);
    end else if (rem_q != '0) begin
      bit_d   = sh_q[0];
      vld_d   = 1'b1;
      sh_d    = sh_q >> 1;
      rem_d   = rem_q - CNT_W'(1);
    end
    // Once the final word is taken the source is shut off until the next start.
    if (start) begin
      active_d = 1'b1;
    end else if (words_d == WC_W'(N_WORDS)) begin
      active_d = 1'b0;
    end else begin
      active_d = active_q;
    end
    s_ready_d = active_d && (rem_d == '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_q      <= '0;
      rem_q     <= '0;
      words_q   <= '0;
      active_q  <= 1'b0;
      s_ready_q <= 1'b0;
      bit_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      rem_q     <= rem_d;
      words_q   <= words_d;
      active_q  <= active_d;
      s_ready_q <= s_ready_d;
      bit_q     <= bit_d;
      vld_q     <= vld_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign bit_data  = bit_q;
  assign bit_valid = vld_q;

endmodule

// File: rtl/sym_dn_lut_loader.sv
// rtl/sym_dn_lut_loader.sv - write-side engine loading the 128x1 decision-node LUT RAM
// Optional readback checksum (rb_addr, lut_rd_data, verify_err) under SYM_DN_LUT_VERIFY_EN.
module sym_dn_lut_loader
  import sym_dn_lut_pkg::*;
#(
  parameter int LUT_DEPTH = DEF_LUT_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic              write_clk,
  input  logic              rstn,
  input  logic              load_start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] write_addr,
  output logic              lut_in,
  output logic              we,
  output logic              load_busy,
  output logic              load_done
`ifdef SYM_DN_LUT_VERIFY_EN
  ,
  output logic [ADDR_W-1:0] rb_addr,
  input  logic              lut_rd_data,
  output logic              verify_err
`endif
);

  if (!lut_geom_ok(LUT_DEPTH, ADDR_W, WORD_W)) begin : g_geom_err
    $error("sym_dn_lut_loader: LUT_DEPTH must be 2**ADDR_W and a multiple of WORD_W");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start;

`ifdef SYM_DN_LUT_VERIFY_EN
  localparam int CNT_W = cnt_width(WORD_W);
  logic [ADDR_W-1:0] rb_addr_q, rb_addr_d;
  logic [WORD_W-1:0] wr_acc_q, wr_acc_d;
  logic [WORD_W-1:0] rd_acc_q, rd_acc_d;
  logic              cmp_q, cmp_d;
  logic              verify_err_q, verify_err_d;
  logic              accept;
`endif

  assign start = (state_q == ST_IDLE) && load_start;

  sym_dn_lut_ser #(
    .WORD_W (WORD_W),
    .N_WORDS(LUT_DEPTH / WORD_W)
  ) u_ser (
    .clk      (write_clk),
    .rstn     (rstn),
    .start    (start),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .bit_data (lut_in),
    .bit_valid(we)
  );

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    // The address advances only after a bit has actually been written, so starvation holds it.
    write_addr_d = we ? write_addr_q + ADDR_W'(1) : write_addr_q;
`ifdef SYM_DN_LUT_VERIFY_EN
    accept       = s_valid && s_ready;
    rb_addr_d    = rb_addr_q;
    wr_acc_d     = wr_acc_q;
    rd_acc_d     = rd_acc_q;
    cmp_d        = cmp_q;
    verify_err_d = verify_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
`ifdef SYM_DN_LUT_VERIFY_EN
          rb_addr_d    = '0;
          wr_acc_d     = '0;
          rd_acc_d     = '0;
          cmp_d        = 1'b0;
          verify_err_d = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
`ifdef SYM_DN_LUT_VERIFY_EN
        if (accept) begin
          wr_acc_d = wr_acc_q ^ s_data;
        end
`endif
        if (we && (write_addr_q == ADDR_W'(LUT_DEPTH - 1))) begin
`ifdef SYM_DN_LUT_VERIFY_EN
          state_d = ST_VERIFY;
`else
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef SYM_DN_LUT_VERIFY_EN
      ST_VERIFY: begin
        if (cmp_q) begin
          cmp_d        = 1'b0;
          verify_err_d = verify_err_q | (wr_acc_q != rd_acc_q);
          state_d      = ST_DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end else begin
          // Bit i of every word lands at an address with low bits i, so XOR it straight into that lane.
          rd_acc_d[rb_addr_q[CNT_W-1:0]] = rd_acc_q[rb_addr_q[CNT_W-1:0]] ^ lut_rd_data;
          rb_addr_d = rb_addr_q + ADDR_W'(1);
          if (rb_addr_q == ADDR_W'(LUT_DEPTH - 1)) begin
            cmp_d = 1'b1;
          end
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      write_addr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SYM_DN_LUT_VERIFY_EN
      rb_addr_q    <= '0;
      wr_acc_q     <= '0;
      rd_acc_q     <= '0;
      cmp_q        <= 1'b0;
      verify_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      write_addr_q <= write_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SYM_DN_LUT_VERIFY_EN
      rb_addr_q    <= rb_addr_d;
      wr_acc_q     <= wr_acc_d;
      rd_acc_q     <= rd_acc_d;
      cmp_q        <= cmp_d;
      verify_err_q <= verify_err_d;
`endif
    end
  end

  assign write_addr = write_addr_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;
`ifdef SYM_DN_LUT_VERIFY_EN
  assign rb_addr    = rb_addr_q;
  assign verify_err = verify_err_q;
`endif

endmodule

// File: tb/tb_sym_dn_lut_loader.sv
// tb/tb_sym_dn_lut_loader.sv - scoreboard bench for sym_dn_lut_loader (readback checks under SYM_DN_LUT_VERIFY_EN)
module tb_sym_dn_lut_loader;

  localparam int ADDR_W = 7;
  localparam int WORD_W = 16;
  localparam int DEPTH  = 128;
`ifdef SYM_DN_LUT_VERIFY_EN
  localparam int DONE_LAT = 257;
`else
  localparam int DONE_LAT = 128;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              b;
  } exp_t;

  logic              write_clk = 1'b0;
  logic              rstn;
  logic              load_start;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] write_addr;
  logic              lut_in;
  logic              we;
  logic              load_busy;
  logic              load_done;
`ifdef SYM_DN_LUT_VERIFY_EN
  logic [ADDR_W-1:0] rb_addr;
  logic              lut_rd_data;
  logic              verify_err;
  logic              flip_en = 1'b0;
`endif

  logic        lut_mem [DEPTH];
  logic [15:0] wtab [9];
  exp_t        exp_q [$];
  logic [15:0] src_q [$];
  int n_chk = 0, n_fail = 0;
  int cyc_n = 0, word_k, we_cnt, gap_cnt, acc_cyc, first_we, done_cyc;
  int stall = 0, stall_word = -1, lat;
  bit src_en = 1'b0, gap_hold_ok;

  always #5 write_clk = ~write_clk;

  sym_dn_lut_loader dut (
    .write_clk  (write_clk),
    .rstn       (rstn),
    .load_start (load_start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .write_addr (write_addr),
    .lut_in     (lut_in),
    .we         (we),
    .load_busy  (load_busy),
    .load_done  (load_done)
`ifdef SYM_DN_LUT_VERIFY_EN
    ,
    .rb_addr    (rb_addr),
    .lut_rd_data(lut_rd_data),
    .verify_err (verify_err)
`endif
  );

  always @(posedge write_clk) if (we === 1'b1) lut_mem[write_addr] <= lut_in;

`ifdef SYM_DN_LUT_VERIFY_EN
  assign lut_rd_data = lut_mem[rb_addr] ^ (flip_en && (rb_addr == 7'h40));
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_vec();
    logic [127:0] v;
    for (int a = 0; a < DEPTH; a++) v[a] = lut_mem[a];
    return v;
  endfunction

  function automatic logic [127:0] exp_vec();
    logic [127:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = wtab[k];
    return v;
  endfunction

  task automatic drive();
    if (stall_word >= 0 && s_ready === 1'b1 && word_k == stall_word) begin
      stall      = 3;
      stall_word = -1;
    end
    if (stall > 0) begin
      s_valid = 1'b0;
      stall--;
    end else begin
      s_valid = src_en && (src_q.size() != 0);
    end
    s_data = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  task automatic cyc();
    logic        fire;
    logic [15:0] fdata;
    exp_t        e;
    fire  = (s_valid === 1'b1) && (s_ready === 1'b1);
    fdata = s_data;
    @(posedge write_clk);
    #1;
    cyc_n++;
    if (fire) begin
      if (acc_cyc < 0) acc_cyc = cyc_n;
      for (int i = 0; i < WORD_W; i++) exp_q.push_back({ADDR_W'((word_k * WORD_W + i) % DEPTH), fdata[i]});
      word_k++;
      void'(src_q.pop_front());
    end
    if (we === 1'b1) begin
      if (first_we < 0) first_we = cyc_n;
      we_cnt++;
      chk("we_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", write_addr, e.addr);
        chk("wr_data", lut_in, e.b);
      end
      if (write_addr === 7'h7F) chk("rdy_low_at_last", s_ready, 1'b0);
    end else if (first_we >= 0 && we_cnt < DEPTH) begin
      gap_cnt++;
      if (write_addr !== 7'h20) gap_hold_ok = 1'b0;
    end
    if (load_done === 1'b1 && done_cyc < 0) done_cyc = cyc_n;
    drive();
  endtask

  task automatic prep(input int n_words, input int stall_after);
    src_q.delete();
    exp_q.delete();
    for (int k = 0; k < n_words; k++) src_q.push_back(wtab[k]);
    word_k = 0; we_cnt = 0; gap_cnt = 0; gap_hold_ok = 1'b1;
    acc_cyc = -1; first_we = -1; done_cyc = -1;
    stall_word = stall_after; stall = 0; src_en = 1'b1;
    drive();
  endtask

  task automatic run_load(input int n_words, input int stall_after, input int mid_pulse_addr, output int l);
    prep(n_words, stall_after);
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    chk("busy_after_start", load_busy, 1'b1);
`ifdef SYM_DN_LUT_VERIFY_EN
    chk("verr_cleared_on_start", verify_err, 1'b0);
`endif
    for (int c = 0; c < 600 && done_cyc < 0; c++) begin
      cyc();
      load_start = (mid_pulse_addr >= 0) && (we === 1'b1) && (int'(write_addr) == mid_pulse_addr);
    end
    load_start = 1'b0;
    chk("done_seen", done_cyc >= 0, 1'b1);
    l = done_cyc - acc_cyc;
  endtask

  initial begin
    rstn = 1'b0; load_start = 1'b0; s_valid = 1'b0; s_data = '0;
    for (int a = 0; a < DEPTH; a++) lut_mem[a] = 1'b0;
    repeat (3) @(posedge write_clk);
    #1;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_write_addr", write_addr, 7'h00);
    chk("rst_lut_in", lut_in, 1'b0);
    chk("rst_load_busy", load_busy, 1'b0);
    chk("rst_load_done", load_done, 1'b0);
`ifdef SYM_DN_LUT_VERIFY_EN
    chk("rst_rb_addr", rb_addr, 7'h00);
    chk("rst_verify_err", verify_err, 1'b0);
`endif
    rstn = 1'b1;
    cyc(); cyc();

    wtab = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 16'hA5A5, 16'h5A5A, 16'h1234, 16'hFEDC, 16'h0000};

    // Abort a load part way through with reset
    prep(8, -1);
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    for (int c = 0; c < 200 && !(we === 1'b1 && write_addr === 7'h25); c++) cyc();
    chk("reached_0x25", write_addr, 7'h25);
    rstn = 1'b0;
    #1;
    chk("abort_we", we, 1'b0);
    chk("abort_write_addr", write_addr, 7'h00);
    chk("abort_lut_in", lut_in, 1'b0);
    chk("abort_s_ready", s_ready, 1'b0);
    chk("abort_load_busy", load_busy, 1'b0);
    chk("abort_load_done", load_done, 1'b0);
    src_en = 1'b0; s_valid = 1'b0; exp_q.delete();
    @(posedge write_clk);
    #1;
    rstn = 1'b1;
    cyc();

    // Gapless reload after the abort
    run_load(8, -1, -1, lat);
    chk("gapless_first_we_lat", first_we - acc_cyc, 0);
    chk("gapless_we_cnt", we_cnt, DEPTH);
    chk("gapless_gaps", gap_cnt, 0);
    chk("gapless_done_lat", lat, DONE_LAT);
    chk("gapless_sb_empty", exp_q.size(), 0);
    chk("gapless_done_busy", load_busy, 1'b0);
    chk("gapless_addr_wrap", write_addr, 7'h00);
`ifdef SYM_DN_LUT_VERIFY_EN
    chk("gapless_verify_err", verify_err, 1'b0);
`endif
    cyc();
    chk("gapless_lut", mem_vec(), exp_vec());
    chk("done_one_cycle", load_done, 1'b0);
    chk("idle_s_ready", s_ready, 1'b0);

    // Source starved for three cycles after two words
    run_load(8, 2, -1, lat);
    chk("starve_gaps", gap_cnt, 3);
    chk("starve_addr_hold", gap_hold_ok, 1'b1);
    chk("starve_we_cnt", we_cnt, DEPTH);
    chk("starve_done_lat", lat, DONE_LAT + 3);
    cyc();
    chk("starve_lut", mem_vec(), exp_vec());

    // Stray load_start mid-load and a ninth word on offer
    for (int k = 0; k < 8; k++) wtab[k] = ~wtab[k];
    wtab[8] = 16'hDEAD;
    run_load(9, -1, 8'h50, lat);
    chk("proto_ninth_left", src_q.size(), 1);
    chk("proto_done_lat", lat, DONE_LAT);
    chk("proto_addr_wrap", write_addr, 7'h00);
    repeat (5) cyc();
    src_en = 1'b0;
    chk("proto_no_extra_we", we_cnt, DEPTH);
    chk("proto_idle_busy", load_busy, 1'b0);
    chk("proto_idle_s_ready", s_ready, 1'b0);
    chk("proto_lut", mem_vec(), exp_vec());

`ifdef SYM_DN_LUT_VERIFY_EN
    // Corrupt one readback bit; the flag must latch until the next start
    flip_en = 1'b1;
    run_load(8, -1, -1, lat);
    chk("flip_verify_err", verify_err, 1'b1);
    chk("flip_done_lat", lat, DONE_LAT);
    src_en = 1'b0;
    repeat (4) cyc();
    chk("flip_verify_sticky", verify_err, 1'b1);
    flip_en = 1'b0;
    run_load(8, -1, -1, lat);
    chk("clean_verify_err", verify_err, 1'b0);
    src_en = 1'b0;
    cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sym_dn_lut_loader.md
Name: sym_dn_lut_loader

Overview:
- Write-side engine for the symmetric decision-node distributed LUT RAM (128x1, one write port, four async read ports).
- Accepts IB LUT contents as a stream of WORD_W-bit words over a valid/ready handshake.
- Serialises each word into one-bit writes at write_addr 0..LUT_DEPTH-1 and drives we.
- Raises load_busy so decoder-side read arbitration holds reads off while we is high.

Parameters:
- LUT_DEPTH, 128: LUT entries; must equal 2**ADDR_W.
- ADDR_W, 7: write address width.
- WORD_W, 16: bits per input word; LUT_DEPTH % WORD_W must be 0. Default gives 8 words per load.

Ports:
- write_clk  in  1  sole clock; LUT RAM writes on the same rising edge.
- rstn  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse that begins a full LUT load.
- s_data  in  WORD_W  input word; bit 0 goes to the lowest address.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept s_data.
- write_addr  out  ADDR_W  LUT write address.
- lut_in  out  1  LUT write data.
- we  out  1  LUT write enable.
- load_busy  out  1  high from the cycle after accepted load_start until load_done.
- load_done  out  1  one-cycle pulse at load completion.
- rb_addr  out  ADDR_W  readback address (SYM_DN_LUT_VERIFY_EN only).
- lut_rd_data  in  1  async LUT read data at rb_addr (SYM_DN_LUT_VERIFY_EN only).
- verify_err  out  1  sticky checksum mismatch (SYM_DN_LUT_VERIFY_EN only).

Behaviour:
- Reset values: s_ready=0, we=0, write_addr=0, lut_in=0, load_busy=0, load_done=0, rb_addr=0, verify_err=0. FSM goes to IDLE and all counters clear.
- All outputs are registered.
- FSM states: IDLE, LOAD, VERIFY (macro only), DONE.
- IDLE -> LOAD on load_start. load_start is ignored in every other state.
- LOAD, buffering:
  - One-word shift buffer plus a bit counter (0..WORD_W-1).
  - s_ready=1 when the buffer is empty, or when it holds the last bit of a word that is being written this cycle. This gives gapless streaming.
  - A word is accepted on the cycle where s_valid and s_ready are both high.
- LOAD, writing:
  - The cycle after acceptance, bit 0 appears on lut_in with we=1 at the current write_addr.
  - Each following cycle shifts one bit out LSB-first and increments write_addr.
  - Latency: acceptance to first write is 1 cycle. A full load with s_valid held high is 1 + LUT_DEPTH cycles from the first acceptance.
- Starvation: if the buffer is empty and s_valid=0, then we=0, write_addr holds, and no bit is lost.
- Load end:
  - After the write at address LUT_DEPTH-1: s_ready=0, then go to VERIFY (macro on) or DONE (macro off).
  - Excess words are never accepted.
  - write_addr wraps to 0 at load end.
- DONE: load_done=1 and load_busy=0 for one cycle, then IDLE.
- Asserting rstn mid-load aborts immediately with we=0. The LUT contents are undefined and must be reloaded.
- we never asserts outside LOAD.
- Applying load_start in the same cycle as a reset release is ignored.

Optional Feature:
- Macro SYM_DN_LUT_VERIFY_EN.
- Defined:
  - During LOAD, a WORD_W-bit accumulator XORs every accepted word.
  - VERIFY sweeps rb_addr 0..LUT_DEPTH-1, one per cycle, with we=0.
  - lut_rd_data is sampled each edge and reassembled into words, which are XORed into a second accumulator.
  - After the final sample, the two accumulators are compared. Mismatch sets verify_err, which stays set until the next load_start or reset.
  - VERIFY adds LUT_DEPTH+1 cycles. load_busy stays high throughout.
- Undefined: the rb_addr, lut_rd_data and verify_err ports, the accumulators and the VERIFY state are removed. LOAD goes directly to DONE.

Decomposition:
- Package sym_dn_lut_pkg holds:
  - the FSM state enum;
  - LUT_DEPTH/ADDR_W/WORD_W defaults;
  - the derived WORDS_PER_LUT = LUT_DEPTH/WORD_W;
  - the compile-time check LUT_DEPTH == 2**ADDR_W.
- One natural sub-module, sym_dn_lut_ser: the word buffer, bit counter and s_ready generation, emitting a bit/valid pair.
- The top level owns the FSM, address counter and verify logic.

Test Plan:
- Reset mid-load: reset at write_addr=0x25 -> we=0 the same cycle, all outputs at reset values; a new load_start then reloads 128 bits from address 0.
- Gapless load: s_valid held high, words 0x0001, 0x8000, 0xFFFF, 0x0000, 0xA5A5, 0x5A5A, 0x1234, 0xFEDC -> first we one cycle after the first acceptance, 128 consecutive we cycles; the LUT model matches bit i of word k at address 16k+i; load_done at cycle 129.
- Starved source: s_valid dropped for 3 cycles after word 2 -> we=0 for exactly those cycles, write_addr holds at 0x20, final LUT content unchanged, load_done delayed by 3 cycles.
- Protocol boundaries: load_start pulsed during LOAD, and a 9th word offered -> both ignored; s_ready=0 after address 127; write_addr returns to 0.
- Verify (macro on): a clean load gives verify_err=0 and load_done at cycle 1+128+129. With one readback bit forced at address 0x40, verify_err=1 and stays high until the next load_start.
- Build with macro off: the block compiles without the readback ports, and the gapless-load scenario still passes.
